// File: rtl/lcd_bus_writer.sv
// rtl/lcd_bus_writer.sv - write-only HD44780-style LCD bus engine with valid/ready host handshake

module lcd_bus_writer #(
    parameter int BUS_4BIT     = 0,
    parameter int SETUP_CYCLES = 2,
    parameter int EN_CYCLES    = 16,
    parameter int HOLD_CYCLES  = 2,
    parameter int NORM_WAIT    = 2000,
    parameter int CLR_WAIT     = 82000,
    parameter int CNT_W        = 17
) (
    input  logic       iCLK,
    input  logic       iRST_N,
    input  logic [7:0] iDATA,
    input  logic       iRS,
    input  logic       iValid,
    output logic       oReady,
    output logic       oDone,
    output logic       oBusy,
    output logic [7:0] LCD_DATA,
    output logic       LCD_RS,
    output logic       LCD_RW,
    output logic       LCD_EN
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_EN_HI,
        S_HOLD,
        S_WAIT
    } state_t;

    // Counter reload values: a state lasting N cycles loads N-1 and leaves when the count hits zero.
    localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(SETUP_CYCLES - 1);
    localparam logic [CNT_W-1:0] EN_LD    = CNT_W'(EN_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] NORM_LD  = CNT_W'(NORM_WAIT - 1);
    localparam logic [CNT_W-1:0] CLR_LD   = CNT_W'(CLR_WAIT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = '0;

    state_t           state;
    state_t           stateNext;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cntNext;
    logic [7:0]       latData;
    logic [7:0]       latDataNext;
    logic             latRs;
    logic             latRsNext;
    logic             nibLow;
    logic             nibLowNext;
    logic [7:0]       lcdDataNext;
    logic             lcdRsNext;
    logic             lcdEnNext;
    logic             doneNext;
    logic             busyNext;
    logic             readyNext;
    logic             cntZero;
    logic             isSlowCmd;

    // Bytes as they appear on the pins: whole byte in 8-bit mode, selected nibble on [7:4] otherwise.
    function automatic logic [7:0] pinByte(input logic [7:0] b, input logic low);
        logic [7:0] r;
        if (BUS_4BIT != 0) begin
            r = low ? {b[3:0], 4'h0} : {b[7:4], 4'h0};
        end else begin
            r = b;
        end
        return r;
    endfunction

    assign LCD_RW    = 1'b0;
    assign cntZero   = (cnt == CNT_ZERO);
    // Clear display and return home need the long execution wait.
    assign isSlowCmd = !latRs && (latData == 8'h01 || latData == 8'h02 || latData == 8'h03);

    // State, counter, latched request and all pin/status outputs are registers.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state    <= S_IDLE;
            cnt      <= CNT_ZERO;
            latData  <= 8'h00;
            latRs    <= 1'b0;
            nibLow   <= 1'b0;
            LCD_DATA <= 8'h00;
            LCD_RS   <= 1'b0;
            LCD_EN   <= 1'b0;
            oDone    <= 1'b0;
            oBusy    <= 1'b0;
            oReady   <= 1'b1;
        end else begin
            state    <= stateNext;
            cnt      <= cntNext;
            latData  <= latDataNext;
            latRs    <= latRsNext;
            nibLow   <= nibLowNext;
            LCD_DATA <= lcdDataNext;
            LCD_RS   <= lcdRsNext;
            LCD_EN   <= lcdEnNext;
            oDone    <= doneNext;
            oBusy    <= busyNext;
            oReady   <= readyNext;
        end
    end

    // Next-state logic; pins hold their values unless a transfer (re)starts, EN is high only in EN_HI.
    always_comb begin
        stateNext   = state;
        cntNext     = cnt;
        latDataNext = latData;
        latRsNext   = latRs;
        nibLowNext  = nibLow;
        lcdDataNext = LCD_DATA;
        lcdRsNext   = LCD_RS;
        lcdEnNext   = 1'b0;
        doneNext    = 1'b0;
        busyNext    = oBusy;
        readyNext   = oReady;

        case (state)
            S_IDLE: begin
                if (iValid) begin
                    stateNext   = S_SETUP;
                    cntNext     = SETUP_LD;
                    latDataNext = iDATA;
                    latRsNext   = iRS;
                    nibLowNext  = 1'b0;
                    lcdDataNext = pinByte(iDATA, 1'b0);
                    lcdRsNext   = iRS;
                    busyNext    = 1'b1;
                    readyNext   = 1'b0;
                end
            end

            S_SETUP: begin
                if (cntZero) begin
                    stateNext = S_EN_HI;
                    cntNext   = EN_LD;
                    lcdEnNext = 1'b1;
                end else begin
                    cntNext   = cnt - CNT_ONE;
                end
            end

            S_EN_HI: begin
                if (cntZero) begin
                    stateNext = S_HOLD;
                    cntNext   = HOLD_LD;
                end else begin
                    cntNext   = cnt - CNT_ONE;
                    lcdEnNext = 1'b1;
                end
            end

            S_HOLD: begin
                if (cntZero) begin
                    if (BUS_4BIT != 0 && !nibLow) begin
                        stateNext   = S_SETUP;
                        cntNext     = SETUP_LD;
                        nibLowNext  = 1'b1;
                        lcdDataNext = pinByte(latData, 1'b1);
                    end else begin
                        stateNext = S_WAIT;
                        cntNext   = isSlowCmd ? CLR_LD : NORM_LD;
                    end
                end else begin
                    cntNext = cnt - CNT_ONE;
                end
            end

            S_WAIT: begin
                if (cntZero) begin
                    stateNext = S_IDLE;
                    cntNext   = CNT_ZERO;
                    doneNext  = 1'b1;
                    busyNext  = 1'b0;
                    readyNext = 1'b1;
                end else begin
                    cntNext = cnt - CNT_ONE;
                end
            end

            default: begin
                stateNext = S_IDLE;
                cntNext   = CNT_ZERO;
                busyNext  = 1'b0;
                readyNext = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_lcd_bus_writer.sv
// tb/tb_lcd_bus_writer.sv - directed self-checking bench for lcd_bus_writer (8-bit and 4-bit instances)

module tb_lcd_bus_writer;

    logic       iCLK;
    logic       iRST_N;

    logic [7:0] d8;
    logic       rs8;
    logic       v8;
    logic       ready8, done8, busy8, lcdRs8, lcdRw8, lcdEn8;
    logic [7:0] lcdData8;

    logic [7:0] d4;
    logic       rs4;
    logic       v4;
    logic       ready4, done4, busy4, lcdRs4, lcdRw4, lcdEn4;
    logic [7:0] lcdData4;

    int checks;
    int errors;

    lcd_bus_writer #(
        .BUS_4BIT(0), .SETUP_CYCLES(2), .EN_CYCLES(4), .HOLD_CYCLES(2),
        .NORM_WAIT(10), .CLR_WAIT(50), .CNT_W(17)
    ) dut8 (
        .iCLK(iCLK), .iRST_N(iRST_N), .iDATA(d8), .iRS(rs8), .iValid(v8),
        .oReady(ready8), .oDone(done8), .oBusy(busy8),
        .LCD_DATA(lcdData8), .LCD_RS(lcdRs8), .LCD_RW(lcdRw8), .LCD_EN(lcdEn8)
    );

    lcd_bus_writer #(
        .BUS_4BIT(1), .SETUP_CYCLES(2), .EN_CYCLES(4), .HOLD_CYCLES(2),
        .NORM_WAIT(10), .CLR_WAIT(50), .CNT_W(17)
    ) dut4 (
        .iCLK(iCLK), .iRST_N(iRST_N), .iDATA(d4), .iRS(rs4), .iValid(v4),
        .oReady(ready4), .oDone(done4), .oBusy(busy4),
        .LCD_DATA(lcdData4), .LCD_RS(lcdRs4), .LCD_RW(lcdRw4), .LCD_EN(lcdEn4)
    );

    initial iCLK = 1'b0;
    always #5 iCLK = ~iCLK;

    // Advance past the next rising edge and settle: samples and drives happen 1 time unit after the edge.
    task automatic tick();
        @(posedge iCLK);
        #1;
    endtask

    // Issue one write and observe it; k counts rising edges after the accepting edge (k = 0).
    task automatic do_write(input bit four, input logic [7:0] d, input logic rs,
                            output int doneAt, output int doneCnt, output int enPulses,
                            output int enHigh, output int enFirst, output logic [7:0] data1,
                            output logic [7:0] data2, output int dataChanges,
                            output logic readyAtDone, output logic rsSeen);
        logic       en, prevEn, dn, rdy, r;
        logic [7:0] dat, prevData;
        doneAt = -1; doneCnt = 0; enPulses = 0; enHigh = 0; enFirst = -1;
        data1 = 8'h00; data2 = 8'h00; dataChanges = 0; readyAtDone = 1'b0; rsSeen = 1'b0;
        prevEn = 1'b0; prevData = 8'h00;
        if (four) begin v4 = 1'b1; d4 = d; rs4 = rs; end
        else      begin v8 = 1'b1; d8 = d; rs8 = rs; end
        tick();
        v4 = 1'b0; v8 = 1'b0;
        for (int k = 0; k < 200; k++) begin
            if (k > 0) tick();
            en  = four ? lcdEn4   : lcdEn8;
            dn  = four ? done4    : done8;
            rdy = four ? ready4   : ready8;
            r   = four ? lcdRs4   : lcdRs8;
            dat = four ? lcdData4 : lcdData8;
            if (k == 0) begin
                data1 = dat; data2 = dat; prevData = dat; rsSeen = r;
            end else if (dat !== prevData) begin
                dataChanges++; data2 = dat; prevData = dat;
            end
            if (en && !prevEn) begin
                enPulses++;
                if (enFirst < 0) enFirst = k;
            end
            if (en) enHigh++;
            prevEn = en;
            if (dn) begin
                doneCnt++;
                if (doneAt < 0) begin doneAt = k; readyAtDone = rdy; end
            end
            if (doneAt >= 0 && k >= doneAt + 3) break;
        end
    endtask

    task automatic test_reset();
        checks++; if (ready8 !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", ready8); end
        checks++; if (busy8 !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy8); end
        checks++; if (done8 !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done8); end
        checks++; if (lcdEn8 !== 1'b0) begin errors++; $display("FAIL reset_en got %b want 0", lcdEn8); end
        checks++; if (lcdData8 !== 8'h00) begin errors++; $display("FAIL reset_data got %h want 00", lcdData8); end
        checks++; if (lcdRs8 !== 1'b0) begin errors++; $display("FAIL reset_rs got %b want 0", lcdRs8); end
        checks++; if (lcdRw8 !== 1'b0) begin errors++; $display("FAIL reset_rw got %b want 0", lcdRw8); end
        checks++; if (ready4 !== 1'b1) begin errors++; $display("FAIL reset_ready4 got %b want 1", ready4); end
    endtask

    task automatic test_data_write();
        int doneAt, doneCnt, enPulses, enHigh, enFirst, dataChanges;
        logic [7:0] data1, data2;
        logic readyAtDone, rsSeen;
        do_write(1'b0, 8'h41, 1'b1, doneAt, doneCnt, enPulses, enHigh, enFirst,
                 data1, data2, dataChanges, readyAtDone, rsSeen);
        checks++; if (data1 !== 8'h41) begin errors++; $display("FAIL data_pins got %h want 41", data1); end
        checks++; if (rsSeen !== 1'b1) begin errors++; $display("FAIL data_rs got %b want 1", rsSeen); end
        checks++; if (dataChanges !== 0) begin errors++; $display("FAIL data_stable got %0d changes want 0", dataChanges); end
        checks++; if (enFirst !== 2) begin errors++; $display("FAIL data_en_rise got %0d want 2", enFirst); end
        checks++; if (enHigh !== 4) begin errors++; $display("FAIL data_en_width got %0d want 4", enHigh); end
        checks++; if (enPulses !== 1) begin errors++; $display("FAIL data_en_pulses got %0d want 1", enPulses); end
        checks++; if (doneAt !== 18) begin errors++; $display("FAIL data_latency got %0d want 18", doneAt); end
        checks++; if (doneCnt !== 1) begin errors++; $display("FAIL data_done_count got %0d want 1", doneCnt); end
        checks++; if (readyAtDone !== 1'b1) begin errors++; $display("FAIL data_ready_at_done got %b want 1", readyAtDone); end
    endtask

    task automatic test_cmd_wait();
        int doneAt, doneCnt, enPulses, enHigh, enFirst, dataChanges;
        logic [7:0] data1, data2;
        logic readyAtDone, rsSeen;
        logic [7:0] bytes [6] = '{8'h01, 8'h38, 8'h02, 8'h03, 8'h04, 8'h01};
        logic       rss   [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        int         lat   [6] = '{58, 18, 58, 58, 18, 18};
        for (int i = 0; i < 6; i++) begin
            do_write(1'b0, bytes[i], rss[i], doneAt, doneCnt, enPulses, enHigh, enFirst,
                     data1, data2, dataChanges, readyAtDone, rsSeen);
            checks++;
            if (doneAt !== lat[i]) begin
                errors++;
                $display("FAIL cmd_latency byte %h rs %b got %0d want %0d", bytes[i], rss[i], doneAt, lat[i]);
            end
            checks++;
            if (rsSeen !== rss[i]) begin errors++; $display("FAIL cmd_rs byte %h got %b want %b", bytes[i], rsSeen, rss[i]); end
        end
    endtask

    task automatic test_nibble_mode();
        int doneAt, doneCnt, enPulses, enHigh, enFirst, dataChanges;
        logic [7:0] data1, data2;
        logic readyAtDone, rsSeen;
        do_write(1'b1, 8'hA5, 1'b1, doneAt, doneCnt, enPulses, enHigh, enFirst,
                 data1, data2, dataChanges, readyAtDone, rsSeen);
        checks++; if (enPulses !== 2) begin errors++; $display("FAIL nib_en_pulses got %0d want 2", enPulses); end
        checks++; if (enHigh !== 8) begin errors++; $display("FAIL nib_en_width got %0d want 8", enHigh); end
        checks++; if (data1 !== 8'hA0) begin errors++; $display("FAIL nib_high got %h want a0", data1); end
        checks++; if (data2 !== 8'h50) begin errors++; $display("FAIL nib_low got %h want 50", data2); end
        checks++; if (dataChanges !== 1) begin errors++; $display("FAIL nib_changes got %0d want 1", dataChanges); end
        checks++; if (doneAt !== 26) begin errors++; $display("FAIL nib_latency got %0d want 26", doneAt); end
        do_write(1'b1, 8'h01, 1'b0, doneAt, doneCnt, enPulses, enHigh, enFirst,
                 data1, data2, dataChanges, readyAtDone, rsSeen);
        checks++; if (doneAt !== 66) begin errors++; $display("FAIL nib_clr_latency got %0d want 66", doneAt); end
        checks++; if (data2 !== 8'h10) begin errors++; $display("FAIL nib_clr_low got %h want 10", data2); end
    endtask

    task automatic test_back_to_back();
        int doneTimes [3];
        int nDone;
        logic [7:0] afterAccept [2];
        bool_loop: begin end
        nDone = 0;
        doneTimes = '{-1, -1, -1};
        afterAccept = '{8'h00, 8'h00};
        v8 = 1'b1; d8 = 8'h10; rs8 = 1'b1;
        tick();
        for (int k = 0; k < 150; k++) begin
            if (k > 0) tick();
            if (nDone >= 1 && nDone <= 2 && doneTimes[nDone-1] == k - 1) afterAccept[nDone-1] = lcdData8;
            if (done8) begin
                if (nDone < 3) doneTimes[nDone] = k;
                nDone++;
                if (nDone == 1) d8 = 8'h11;
                else if (nDone == 2) d8 = 8'h12;
                else v8 = 1'b0;
            end
        end
        v8 = 1'b0;
        checks++; if (nDone !== 3) begin errors++; $display("FAIL b2b_done_count got %0d want 3", nDone); end
        checks++; if (doneTimes[0] !== 18) begin errors++; $display("FAIL b2b_first got %0d want 18", doneTimes[0]); end
        checks++; if (doneTimes[1] - doneTimes[0] !== 19) begin errors++; $display("FAIL b2b_gap1 got %0d want 19", doneTimes[1] - doneTimes[0]); end
        checks++; if (doneTimes[2] - doneTimes[1] !== 19) begin errors++; $display("FAIL b2b_gap2 got %0d want 19", doneTimes[2] - doneTimes[1]); end
        checks++; if (afterAccept[0] !== 8'h11) begin errors++; $display("FAIL b2b_byte2 got %h want 11", afterAccept[0]); end
        checks++; if (afterAccept[1] !== 8'h12) begin errors++; $display("FAIL b2b_byte3 got %h want 12", afterAccept[1]); end
    endtask

    task automatic test_busy_ignore();
        int nDone, nEn, badPins, badReady;
        logic prevEn;
        nDone = 0; nEn = 0; badPins = 0; badReady = 0; prevEn = 1'b0;
        v8 = 1'b1; d8 = 8'h55; rs8 = 1'b1;
        tick();
        for (int k = 0; k < 60; k++) begin
            if (k > 0) tick();
            if (done8) begin nDone++; v8 = 1'b0; end
            if (nDone == 0) begin
                if (lcdData8 !== 8'h55 || lcdRs8 !== 1'b1) badPins++;
                if (ready8 !== 1'b0 || busy8 !== 1'b1) badReady++;
            end
            if (lcdEn8 && !prevEn) nEn++;
            prevEn = lcdEn8;
            d8 = 8'($urandom_range(0, 255));
            rs8 = ~rs8;
        end
        v8 = 1'b0;
        checks++; if (badPins !== 0) begin errors++; $display("FAIL busy_pins got %0d bad cycles want 0", badPins); end
        checks++; if (badReady !== 0) begin errors++; $display("FAIL busy_status got %0d bad cycles want 0", badReady); end
        checks++; if (nEn !== 1) begin errors++; $display("FAIL busy_en_pulses got %0d want 1", nEn); end
        checks++; if (nDone !== 1) begin errors++; $display("FAIL busy_done_count got %0d want 1", nDone); end
    endtask

    task automatic test_async_reset();
        int waitCnt, nDone;
        int doneAt, doneCnt, enPulses, enHigh, enFirst, dataChanges;
        logic [7:0] data1, data2;
        logic readyAtDone, rsSeen;
        v8 = 1'b1; d8 = 8'h7E; rs8 = 1'b1;
        tick();
        v8 = 1'b0;
        waitCnt = 0;
        while (lcdEn8 !== 1'b1 && waitCnt < 20) begin tick(); waitCnt++; end
        checks++; if (lcdEn8 !== 1'b1) begin errors++; $display("FAIL rst_reach_en got %b want 1", lcdEn8); end
        #1 iRST_N = 1'b0;
        #1;
        checks++; if (lcdEn8 !== 1'b0) begin errors++; $display("FAIL rst_async_en got %b want 0", lcdEn8); end
        checks++; if (lcdData8 !== 8'h00) begin errors++; $display("FAIL rst_async_data got %h want 00", lcdData8); end
        checks++; if (lcdRs8 !== 1'b0) begin errors++; $display("FAIL rst_async_rs got %b want 0", lcdRs8); end
        checks++; if (busy8 !== 1'b0) begin errors++; $display("FAIL rst_async_busy got %b want 0", busy8); end
        nDone = 0;
        for (int k = 0; k < 3; k++) begin tick(); if (done8) nDone++; end
        #2 iRST_N = 1'b1;
        for (int k = 0; k < 30; k++) begin tick(); if (done8) nDone++; end
        checks++; if (nDone !== 0) begin errors++; $display("FAIL rst_no_done got %0d want 0", nDone); end
        checks++; if (ready8 !== 1'b1) begin errors++; $display("FAIL rst_ready got %b want 1", ready8); end
        do_write(1'b0, 8'h38, 1'b0, doneAt, doneCnt, enPulses, enHigh, enFirst,
                 data1, data2, dataChanges, readyAtDone, rsSeen);
        checks++; if (doneAt !== 18) begin errors++; $display("FAIL rst_after_latency got %0d want 18", doneAt); end
        checks++; if (data1 !== 8'h38) begin errors++; $display("FAIL rst_after_data got %h want 38", data1); end
    endtask

    initial begin
        checks = 0; errors = 0;
        iRST_N = 1'b0;
        d8 = 8'h00; rs8 = 1'b0; v8 = 1'b0;
        d4 = 8'h00; rs4 = 1'b0; v4 = 1'b0;
        tick(); tick();
        test_reset();
        #2 iRST_N = 1'b1;
        tick();
        test_data_write();
        test_cmd_wait();
        test_nibble_mode();
        test_back_to_back();
        test_busy_ignore();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
